// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the CPU (port C) and the
// debug/loader master (port D); accesses are serialised with a req/ack handshake.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wd,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [DW-1:0]   c_rdata_q, c_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            pick_dbg;

  // Debug wins when it is the only requester or when the rr pointer favours it.
  assign pick_dbg = d_req & (~c_req | rr_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          state_d = ACCESS;
          owner_d = pick_dbg;
          we_d    = pick_dbg ? d_we    : c_we;
          addr_d  = pick_dbg ? d_addr  : c_addr;
          wdata_d = pick_dbg ? d_wdata : c_wdata;
          cnt_d   = LAT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          if (!we_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         c_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wd    = 1'b0;
    c_ack     = 1'b0;
    d_ack     = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_rd    = ~we_q;
      mem_wd    = we_q;
    end
    if (state_q == ACK) begin
      c_ack = ~owner_q;
      d_ack = owner_q;
    end
  end

  assign owner   = owner_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3), a latency-accurate memory
// responder, directed scenarios and a transaction-level reference model for random traffic.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT [2] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          c_req     [2];
  logic          c_we      [2];
  logic [AW-1:0] c_addr    [2];
  logic [DW-1:0] c_wdata   [2];
  logic          c_ack     [2];
  logic [DW-1:0] c_rdata   [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [AW-1:0] d_addr    [2];
  logic [DW-1:0] d_wdata   [2];
  logic          d_ack     [2];
  logic [DW-1:0] d_rdata   [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic          mem_wd    [2];
  logic          mem_rd    [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];
  logic          owner     [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(rst[0]),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_ack(c_ack[0]), .c_rdata(c_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wd(mem_wd[0]),
    .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(rst[1]),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_ack(c_ack[1]), .c_rdata(c_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wd(mem_wd[1]),
    .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  // Initial memory image; 0x10 holds the well-known read pattern.
  function automatic logic [31:0] dflt(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hC0FFEE, a};
  endfunction

  // Memory responder: data is only valid on the MEM_LAT-th strobe cycle, garbage before.
  logic [DW-1:0] resp_mem [2][256];
  bit            resp_wr  [2][256];
  int            scnt     [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_wd[k]) begin
        resp_mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
        resp_wr[k][mem_addr[k][7:0]]  <= 1'b1;
      end
      scnt[k] <= (mem_rd[k] || mem_wd[k]) ? scnt[k] + 1 : 0;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = 32'hBAD0_BAD0;
      if (mem_rd[k] && scnt[k] == LAT[k] - 1)
        mem_rdata[k] = resp_wr[k][mem_addr[k][7:0]] ? resp_mem[k][mem_addr[k][7:0]]
                                                     : dflt(mem_addr[k][7:0]);
    end
  end

  // Reference memory contents as the transaction model expects them.
  logic [31:0] model_mem [2][256];
  bit          model_wr  [2][256];

  function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
    return model_wr[k][a[7:0]] ? model_mem[k][a[7:0]] : dflt(a[7:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) rst[k] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy[k], c_ack[k], d_ack[k], mem_rd[k], mem_wd[k], owner[k]} !== 6'b0) begin
        failures++;
        $display("FAIL reset_ctrl k=%0d got %b want 000000", k,
                 {busy[k], c_ack[k], d_ack[k], mem_rd[k], mem_wd[k], owner[k]});
      end
      checks++;
      if ({mem_addr[k], mem_wdata[k]} !== 64'd0) begin
        failures++;
        $display("FAIL reset_bus k=%0d got %h want 0", k, {mem_addr[k], mem_wdata[k]});
      end
      checks++;
      if ({c_rdata[k], d_rdata[k]} !== 64'd0) begin
        failures++;
        $display("FAIL reset_rdata k=%0d got %h want 0", k, {c_rdata[k], d_rdata[k]});
      end
    end
    for (int k = 0; k < 2; k++) rst[k] = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    c_we[0] = 1'b0; c_addr[0] = 32'h10; c_req[0] = 1'b1;
    tick();
    checks++;
    if ({mem_rd[0], mem_wd[0], c_ack[0], d_ack[0]} !== 4'b1000 || mem_addr[0] !== 32'h10) begin
      failures++;
      $display("FAIL cpu_read_access got rd/wd/ca/da=%b addr=%h want 1000 addr=10",
               {mem_rd[0], mem_wd[0], c_ack[0], d_ack[0]}, mem_addr[0]);
    end
    tick();
    checks++;
    if ({c_ack[0], d_ack[0], mem_rd[0], mem_wd[0]} !== 4'b1000) begin
      failures++;
      $display("FAIL cpu_read_ack got ca/da/rd/wd=%b want 1000",
               {c_ack[0], d_ack[0], mem_rd[0], mem_wd[0]});
    end
    checks++;
    if (c_rdata[0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL cpu_read_data got %h want deadbeef", c_rdata[0]);
    end
    c_req[0] = 1'b0;
    tick();
    checks++;
    if ({busy[0], c_ack[0], d_ack[0]} !== 3'b000 || c_rdata[0] !== 32'hDEAD_BEEF
        || d_rdata[0] !== 32'd0) begin
      failures++;
      $display("FAIL cpu_read_idle got b/ca/da=%b c_rdata=%h d_rdata=%h want 000 deadbeef 0",
               {busy[0], c_ack[0], d_ack[0]}, c_rdata[0], d_rdata[0]);
    end
  endtask

  task automatic test_debug_write();
    d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'h1234_5678; d_req[0] = 1'b1;
    model_wr[0][8'h40]  = 1'b1;
    model_mem[0][8'h40] = 32'h1234_5678;
    tick();
    checks++;
    if ({mem_wd[0], mem_rd[0], owner[0]} !== 3'b101) begin
      failures++;
      $display("FAIL dbg_write_strobe got wd/rd/owner=%b want 101", {mem_wd[0], mem_rd[0], owner[0]});
    end
    checks++;
    if ({mem_addr[0], mem_wdata[0]} !== {32'h40, 32'h1234_5678}) begin
      failures++;
      $display("FAIL dbg_write_bus got %h want 0000004012345678", {mem_addr[0], mem_wdata[0]});
    end
    tick();
    checks++;
    if ({d_ack[0], c_ack[0]} !== 2'b10 || c_rdata[0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL dbg_write_ack got da/ca=%b c_rdata=%h want 10 deadbeef",
               {d_ack[0], c_ack[0]}, c_rdata[0]);
    end
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    tick();
    checks++;
    if (d_ack[0] !== 1'b0 || d_rdata[0] !== 32'd0) begin
      failures++;
      $display("FAIL dbg_write_after got d_ack=%b d_rdata=%h want 0 0", d_ack[0], d_rdata[0]);
    end
  endtask

  task automatic test_both();
    int order [$];
    int exp_order [4] = '{0, 1, 0, 1};
    int nc = 0;
    int nd = 0;
    rst[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    c_we[0] = 1'b0; c_addr[0] = 32'h20;
    d_we[0] = 1'b0; d_addr[0] = 32'h24;
    c_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int t = 0; t < 40 && order.size() < 4; t++) begin
      tick();
      checks++;
      if (c_ack[0] && d_ack[0]) begin
        failures++;
        $display("FAIL both_double_ack cyc=%0d got c_ack=1 d_ack=1 want at most one", cyc);
      end
      if (c_ack[0]) begin
        order.push_back(0);
        nc++;
        checks++;
        if (c_rdata[0] !== dflt(8'h20) || owner[0] !== 1'b0) begin
          failures++;
          $display("FAIL both_cpu_ack got rdata=%h owner=%b want %h 0", c_rdata[0], owner[0], dflt(8'h20));
        end
      end
      if (d_ack[0]) begin
        order.push_back(1);
        nd++;
        checks++;
        if (d_rdata[0] !== dflt(8'h24) || owner[0] !== 1'b1) begin
          failures++;
          $display("FAIL both_dbg_ack got rdata=%h owner=%b want %h 1", d_rdata[0], owner[0], dflt(8'h24));
        end
      end
      c_req[0] = (nc < 2) && !c_ack[0];
      d_req[0] = (nd < 2) && !d_ack[0];
    end
    checks++;
    if (order.size() != 4) begin
      failures++;
      $display("FAIL both_timeout got %0d acks want 4", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        failures++;
        $display("FAIL both_order idx=%0d got master %0d want %0d", i, order[i], exp_order[i]);
      end
    end
    c_req[0] = 1'b0; d_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_lat3();
    int strobes = 0;
    int ack_at  = -1;
    c_we[1] = 1'b0; c_addr[1] = 32'h30; c_req[1] = 1'b1;
    for (int t = 1; t <= 10 && ack_at < 0; t++) begin
      tick();
      if (mem_rd[1]) strobes++;
      if (c_ack[1]) begin
        ack_at   = t;
        c_req[1] = 1'b0;
      end
    end
    checks++;
    if (strobes != 3 || ack_at != 4) begin
      failures++;
      $display("FAIL lat3_timing got strobes=%0d ack_at=%0d want 3 4", strobes, ack_at);
    end
    checks++;
    if (c_rdata[1] !== dflt(8'h30)) begin
      failures++;
      $display("FAIL lat3_data got %h want %h", c_rdata[1], dflt(8'h30));
    end
    c_req[1] = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    c_we[1] = 1'b0; c_addr[1] = 32'h10; c_req[1] = 1'b1;
    tick();
    c_addr[1] = 32'h99; c_we[1] = 1'b1; c_wdata[1] = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_addr[1] !== 32'h10 || {mem_rd[1], mem_wd[1]} !== 2'b10) begin
        failures++;
        $display("FAIL addr_change cycle=%0d got addr=%h rd/wd=%b want 10 10", i, mem_addr[1],
                 {mem_rd[1], mem_wd[1]});
      end
      tick();
    end
    checks++;
    if (c_ack[1] !== 1'b1 || c_rdata[1] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL addr_change_ack got ack=%b rdata=%h want 1 deadbeef", c_ack[1], c_rdata[1]);
    end
    c_req[1] = 1'b0; c_we[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit saw_ack = 1'b0;
    int ack_at  = -1;
    c_we[1] = 1'b0; c_addr[1] = 32'h34; c_req[1] = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy[1], mem_rd[1]} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_pre got busy/rd=%b want 11", {busy[1], mem_rd[1]});
    end
    #2;
    rst[1] = 1'b0;
    #1;
    checks++;
    if ({busy[1], mem_rd[1], mem_wd[1], c_ack[1]} !== 4'b0000 || c_rdata[1] !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_async got b/rd/wd/ack=%b rdata=%h want 0000 0",
               {busy[1], mem_rd[1], mem_wd[1], c_ack[1]}, c_rdata[1]);
    end
    c_req[1] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t == 1) rst[1] = 1'b1;
      if (c_ack[1] || busy[1]) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin
      failures++;
      $display("FAIL rst_mid_dropped got ack/busy after reset want none");
    end
    c_addr[1] = 32'h38; c_req[1] = 1'b1;
    for (int t = 1; t <= 10 && ack_at < 0; t++) begin
      tick();
      if (c_ack[1]) begin
        ack_at   = t;
        c_req[1] = 1'b0;
      end
    end
    checks++;
    if (ack_at != 4 || c_rdata[1] !== dflt(8'h38)) begin
      failures++;
      $display("FAIL rst_mid_fresh got ack_at=%0d rdata=%h want 4 %h", ack_at, c_rdata[1], dflt(8'h38));
    end
    c_req[1] = 1'b0;
    tick();
  endtask

  task automatic test_random(input int k);
    int          next_free;
    int          g = 0;
    bit          act = 1'b0;
    bit          m = 1'b0;
    bit          twe = 1'b0;
    bit          rr = 1'b0;
    bit          exp_own = 1'b0;
    bit          in_acc, in_ack;
    logic [31:0] ta = '0, twd = '0, rd_exp = '0;
    logic [31:0] exp_rd [2];
    logic [5:0]  exp_ctrl, got_ctrl;
    logic [63:0] exp_bus;
    rst[k] = 1'b0;
    tick();
    rst[k] = 1'b1;
    next_free = cyc;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 400; i++) begin
      if (!act && cyc >= next_free && (c_req[k] || d_req[k])) begin
        m   = d_req[k] && (!c_req[k] || rr);
        twe = m ? d_we[k] : c_we[k];
        ta  = m ? d_addr[k] : c_addr[k];
        twd = m ? d_wdata[k] : c_wdata[k];
        rd_exp = model_read(k, ta);
        if (twe) begin
          model_wr[k][ta[7:0]]  = 1'b1;
          model_mem[k][ta[7:0]] = twd;
        end
        g = cyc; act = 1'b1; rr = !m;
        next_free = cyc + LAT[k] + 2;
      end
      tick();
      in_acc = act && cyc > g && cyc <= g + LAT[k];
      in_ack = act && cyc == g + LAT[k] + 1;
      if (act && cyc == g + 1) exp_own = m;
      if (in_ack && !twe) exp_rd[m] = rd_exp;
      exp_ctrl = {in_acc || in_ack, in_acc && !twe, in_acc && twe, in_ack && !m, in_ack && m, exp_own};
      got_ctrl = {busy[k], mem_rd[k], mem_wd[k], c_ack[k], d_ack[k], owner[k]};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        failures++;
        $display("FAIL rnd_ctrl k=%0d cyc=%0d busy/rd/wd/ca/da/own got %b want %b", k, cyc, got_ctrl, exp_ctrl);
      end
      exp_bus = in_acc ? {ta, twd} : 64'd0;
      checks++;
      if ({mem_addr[k], mem_wdata[k]} !== exp_bus) begin
        failures++;
        $display("FAIL rnd_bus k=%0d cyc=%0d got %h want %h", k, cyc, {mem_addr[k], mem_wdata[k]}, exp_bus);
      end
      checks++;
      if ({c_rdata[k], d_rdata[k]} !== {exp_rd[0], exp_rd[1]}) begin
        failures++;
        $display("FAIL rnd_rdata k=%0d cyc=%0d got %h want %h", k, cyc, {c_rdata[k], d_rdata[k]},
                 {exp_rd[0], exp_rd[1]});
      end
      if (in_ack) act = 1'b0;
      if (c_ack[k]) c_req[k] = 1'b0;
      else if (!c_req[k] || (act && !m)) begin
        if (c_req[k] || $urandom_range(0, 1) == 1) begin
          c_req[k]   = 1'b1;
          c_we[k]    = 1'($urandom_range(0, 1));
          c_addr[k]  = 32'($urandom_range(0, 15)) << 2;
          c_wdata[k] = $urandom;
        end
      end
      if (d_ack[k]) d_req[k] = 1'b0;
      else if (!d_req[k] || (act && m)) begin
        if (d_req[k] || $urandom_range(0, 1) == 1) begin
          d_req[k]   = 1'b1;
          d_we[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = 32'($urandom_range(0, 15)) << 2;
          d_wdata[k] = $urandom;
        end
      end
    end
    c_req[k] = 1'b0;
    d_req[k] = 1'b0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    test_reset();
    test_cpu_read();
    test_debug_write();
    test_both();
    test_lat3();
    test_addr_change();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
